// File: rtl/axi_full_mem_responder.sv
// AXI4-full responder backed by a byte-writable dual-port RAM.
// Read and write channels are independent, with one burst outstanding on each.
module axi_full_mem_responder #(
  parameter int                    DATA_WIDTH     = 128,
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    MEM_WORDS_LOG2 = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 32'h0023ec00
) (
  input  logic                      S_AXI_ACLK,
  input  logic                      S_AXI_ARESETN,
  input  logic [ADDR_WIDTH-1:0]     araddr,
  input  logic [7:0]                arlen,
  input  logic [1:0]                arburst,
  input  logic                      arvalid,
  output logic                      arready,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic [1:0]                rresp,
  output logic                      rlast,
  output logic                      rvalid,
  input  logic                      rready,
  input  logic [ADDR_WIDTH-1:0]     awaddr,
  input  logic [7:0]                awlen,
  input  logic [1:0]                awburst,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH/8-1:0]   wstrb,
  input  logic                      wlast,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [1:0]                bresp,
  output logic                      bvalid,
  input  logic                      bready
);

  localparam int BEAT_BYTES = DATA_WIDTH / 8;
  localparam int BYTE_SHIFT = $clog2(BEAT_BYTES);
  localparam int DEPTH      = 1 << MEM_WORDS_LOG2;
  localparam logic [ADDR_WIDTH:0] ONE_EXT   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = ONE_EXT << (MEM_WORDS_LOG2 + BYTE_SHIFT);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  // Whole-burst check done once at the address handshake; 33-bit math avoids wrap.
  function automatic logic range_err(input logic [ADDR_WIDTH-1:0] addr,
                                     input logic [7:0]            len,
                                     input logic [1:0]            burst);
    logic [ADDR_WIDTH:0] off;
    logic [ADDR_WIDTH:0] span;
    off  = {1'b0, addr} - {1'b0, BASE_ADDR};
    span = ({{(ADDR_WIDTH-7){1'b0}}, len} + ONE_EXT) << BYTE_SHIFT;
    return (addr < BASE_ADDR) || ((off + span) > MEM_BYTES) || (burst != BURST_INCR);
  endfunction

  function automatic logic [MEM_WORDS_LOG2-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
    return MEM_WORDS_LOG2'((addr - BASE_ADDR) >> BYTE_SHIFT);
  endfunction

  r_state_t                  r_state_q, r_state_d;
  w_state_t                  w_state_q, w_state_d;
  logic                      arready_q, arready_d;
  logic                      rvalid_q, rvalid_d;
  logic                      rlast_q, rlast_d;
  logic [1:0]                rresp_q, rresp_d;
  logic                      awready_q, awready_d;
  logic                      wready_q, wready_d;
  logic                      bvalid_q, bvalid_d;
  logic [1:0]                bresp_q, bresp_d;

  logic [MEM_WORDS_LOG2-1:0] r_idx_q, r_idx_d;
  logic [7:0]                r_beat_q, r_beat_d;
  logic [7:0]                r_len_q, r_len_d;
  logic                      r_err_q, r_err_d;
  logic [MEM_WORDS_LOG2-1:0] w_idx_q, w_idx_d;
  logic [7:0]                w_beat_q, w_beat_d;
  logic [7:0]                w_len_q, w_len_d;
  logic                      w_err_q, w_err_d;
  logic                      w_lerr_q, w_lerr_d;

  logic [DATA_WIDTH-1:0]     mem [DEPTH];
  logic [DATA_WIDTH-1:0]     ram_rdata_q;
  logic                      ram_re;
  logic                      ram_we;

  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rresp_d   = rresp_q;
    r_idx_d   = r_idx_q;
    r_beat_d  = r_beat_q;
    r_len_d   = r_len_q;
    r_err_d   = r_err_q;
    case (r_state_q)
      R_IDLE: if (arvalid) begin
        r_idx_d   = word_idx(araddr);
        r_len_d   = arlen;
        r_err_d   = range_err(araddr, arlen, arburst);
        r_beat_d  = 8'd0;
        arready_d = 1'b0;
        r_state_d = R_FETCH;
      end
      R_FETCH: begin
        rvalid_d  = 1'b1;
        rlast_d   = (r_beat_q == r_len_q);
        rresp_d   = r_err_q ? RESP_SLVERR : RESP_OKAY;
        r_state_d = R_DATA;
      end
      R_DATA: if (rready) begin
        rvalid_d = 1'b0;
        rlast_d  = 1'b0;
        if (rlast_q) begin
          rresp_d   = RESP_OKAY;
          arready_d = 1'b1;
          r_state_d = R_IDLE;
        end else begin
          r_idx_d   = r_idx_q + 1'b1;
          r_beat_d  = r_beat_q + 8'd1;
          r_state_d = R_FETCH;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // The burst ends on the beat count; a misplaced wlast only poisons the response.
  always_comb begin
    w_state_d = w_state_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    w_idx_d   = w_idx_q;
    w_beat_d  = w_beat_q;
    w_len_d   = w_len_q;
    w_err_d   = w_err_q;
    w_lerr_d  = w_lerr_q;
    case (w_state_q)
      W_IDLE: if (awvalid) begin
        w_idx_d   = word_idx(awaddr);
        w_len_d   = awlen;
        w_err_d   = range_err(awaddr, awlen, awburst);
        w_beat_d  = 8'd0;
        w_lerr_d  = 1'b0;
        awready_d = 1'b0;
        wready_d  = 1'b1;
        w_state_d = W_DATA;
      end
      W_DATA: if (wvalid) begin
        if (w_beat_q == w_len_q) begin
          wready_d  = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = (w_err_q || w_lerr_q || !wlast) ? RESP_SLVERR : RESP_OKAY;
          w_state_d = W_RESP;
        end else begin
          w_idx_d  = w_idx_q + 1'b1;
          w_beat_d = w_beat_q + 8'd1;
          w_lerr_d = w_lerr_q | wlast;
        end
      end
      W_RESP: if (bready) begin
        bvalid_d  = 1'b0;
        bresp_d   = RESP_OKAY;
        awready_d = 1'b1;
        w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state_q <= R_IDLE;
      w_state_q <= W_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      w_state_q <= w_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rresp_q   <= rresp_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    r_idx_q  <= r_idx_d;
    r_beat_q <= r_beat_d;
    r_len_q  <= r_len_d;
    r_err_q  <= r_err_d;
    w_idx_q  <= w_idx_d;
    w_beat_q <= w_beat_d;
    w_len_q  <= w_len_d;
    w_err_q  <= w_err_d;
    w_lerr_q <= w_lerr_d;
  end

  // Read-first RAM: a same-cycle write to the fetched word is seen on the next fetch only.
  assign ram_re = (r_state_q == R_FETCH);
  assign ram_we = (w_state_q == W_DATA) && wvalid && !w_err_q;

  always_ff @(posedge S_AXI_ACLK) begin
    if (ram_we) begin
      for (int b = 0; b < BEAT_BYTES; b++) begin
        if (wstrb[b]) mem[w_idx_q][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    if (ram_re) ram_rdata_q <= mem[r_idx_q];
  end

  assign rdata   = (rvalid_q && !r_err_q) ? ram_rdata_q : '0;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rlast   = rlast_q;
  assign rresp   = rresp_q;
  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;

endmodule

// File: tb/tb_axi_full_mem_responder.sv
// Directed bench for axi_full_mem_responder: burst reads/writes, strobes, range and
// burst-type errors, wlast mismatch, read stalls with a concurrent write, and mid-burst reset.
module tb_axi_full_mem_responder;

  localparam logic [31:0] BASE = 32'h0023ec00;
  localparam logic [1:0]  INCR = 2'b01;
  localparam logic [1:0]  WRAP = 2'b10;

  logic         clk;
  logic         rst_n;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready;
  logic [127:0] rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic [1:0]   awburst;
  logic         awvalid;
  logic         awready;
  logic [127:0] wdata;
  logic [15:0]  wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;

  int n_cmp = 0;
  int n_err = 0;
  logic [127:0] wbuf [16];
  logic [127:0] edat [16];

  axi_full_mem_responder dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .araddr(araddr), .arlen(arlen), .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awlen(awlen), .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic ar_phase(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          output bit ok);
    int n;
    araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 100) begin @(posedge clk); #1; n++; end
    ok = arready;
    if (!ok) check("ar_timeout", 128'(0), 128'(1));
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic write_burst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                             input logic [15:0] strb, input int last_at, output logic [1:0] resp);
    int n;
    resp = 2'bxx;
    awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 100) begin @(posedge clk); #1; n++; end
    if (!awready) begin check("aw_timeout", 128'(0), 128'(1)); awvalid = 1'b0; return; end
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wdata = wbuf[i]; wstrb = strb; wlast = (i == last_at); wvalid = 1'b1;
      n = 0;
      while (!wready && n < 100) begin @(posedge clk); #1; n++; end
      if (!wready) begin check("w_timeout", 128'(0), 128'(1)); wvalid = 1'b0; return; end
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    check("w_ready_after_last", 128'(wready), 128'(0));
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < 100) begin @(posedge clk); #1; n++; end
    if (!bvalid) check("b_timeout", 128'(0), 128'(1));
    resp = bresp;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  // Expected beats come from edat; rlast is expected on beat len only; every beat
  // must follow the previous handshake (or the AR handshake) by exactly one fetch cycle.
  task automatic read_burst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [1:0] exp_resp, input bit stall, input string tag);
    int n;
    bit ok;
    ar_phase(addr, len, burst, ok);
    if (!ok) return;
    check({tag, "_fetch_novalid"}, 128'(rvalid), 128'(0));
    rready = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      n = 0;
      while (!rvalid && n < 50) begin @(posedge clk); #1; n++; end
      check({tag, "_gap"}, 128'(n), 128'(1));
      if (!rvalid) begin rready = 1'b0; return; end
      check({tag, "_data"}, rdata, edat[i]);
      check({tag, "_resp"}, 128'(rresp), 128'(exp_resp));
      check({tag, "_last"}, 128'(rlast), 128'(i == int'(len)));
      if (stall && i == 2) begin
        rready = 1'b0;
        repeat (2) begin
          @(posedge clk); #1;
          check({tag, "_stall_vld"}, 128'(rvalid), 128'(1));
          check({tag, "_stall_data"}, rdata, edat[i]);
          check({tag, "_stall_last"}, 128'(rlast), 128'(0));
        end
        rready = 1'b1;
      end
      @(posedge clk); #1;
    end
    rready = 1'b0;
    check({tag, "_idle_arready"}, 128'(arready), 128'(1));
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0] resp;
    logic [127:0] merged;
    int cnt;
    int n;
    bit ok;

    rst_n = 1'b0;
    araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_arready", 128'(arready), 128'(1));
    check("rst_awready", 128'(awready), 128'(1));
    check("rst_rvalid",  128'(rvalid),  128'(0));
    check("rst_rlast",   128'(rlast),   128'(0));
    check("rst_wready",  128'(wready),  128'(0));
    check("rst_bvalid",  128'(bvalid),  128'(0));
    check("rst_rresp",   128'(rresp),   128'(0));
    check("rst_bresp",   128'(bresp),   128'(0));
    check("rst_rdata",   rdata,         128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Preload words 0..15 with their own index.
    for (int k = 0; k < 16; k++) wbuf[k] = 128'(k);
    write_burst(BASE, 8'd15, INCR, 16'hffff, 15, resp);
    check("preload_bresp", 128'(resp), 128'(0));

    // 1) Four-beat read from word 2.
    for (int k = 0; k < 4; k++) edat[k] = 128'(k + 2);
    read_burst(BASE + 32'h20, 8'd3, INCR, 2'b00, 1'b0, "t1");

    // 2) Two-beat write then read back.
    wbuf[0] = {32{4'hA}};
    wbuf[1] = {32{4'hB}};
    write_burst(BASE, 8'd1, INCR, 16'hffff, 1, resp);
    check("t2_bresp", 128'(resp), 128'(0));
    edat[0] = {32{4'hA}};
    edat[1] = {32{4'hB}};
    read_burst(BASE, 8'd1, INCR, 2'b00, 1'b0, "t2");

    // 3) Partial strobe over an all-ones word.
    wbuf[0] = {128{1'b1}};
    write_burst(BASE, 8'd0, INCR, 16'hffff, 0, resp);
    check("t3_fill_bresp", 128'(resp), 128'(0));
    wbuf[0] = 128'h0123456789abcdef_fedcba9876543210;
    write_burst(BASE, 8'd0, INCR, 16'h00ff, 0, resp);
    check("t3_strb_bresp", 128'(resp), 128'(0));
    merged = 128'hffffffffffffffff_fedcba9876543210;
    edat[0] = merged;
    read_burst(BASE, 8'd0, INCR, 2'b00, 1'b0, "t3");

    // 4) Below-base read and WRAP write are rejected; RAM untouched.
    edat[0] = '0;
    read_burst(BASE - 32'h10, 8'd0, INCR, 2'b10, 1'b0, "t4_low");
    wbuf[0] = 128'h5555;
    write_burst(BASE, 8'd0, WRAP, 16'hffff, 0, resp);
    check("t4_wrap_bresp", 128'(resp), 128'(2));
    edat[0] = merged;
    read_burst(BASE, 8'd0, INCR, 2'b00, 1'b0, "t4_keep");

    // Top word is in range for one beat, out of range for two.
    wbuf[0] = 128'hcafe_0000_0000_0000_0000_0000_0000_beef;
    write_burst(BASE + 32'hfff0, 8'd0, INCR, 16'hffff, 0, resp);
    check("top_bresp", 128'(resp), 128'(0));
    edat[0] = 128'hcafe_0000_0000_0000_0000_0000_0000_beef;
    read_burst(BASE + 32'hfff0, 8'd0, INCR, 2'b00, 1'b0, "top_rd");
    edat[0] = '0; edat[1] = '0;
    read_burst(BASE + 32'hfff0, 8'd1, INCR, 2'b10, 1'b0, "top_over");

    // Early wlast: data still commits, response is SLVERR.
    wbuf[0] = {32{4'hC}};
    wbuf[1] = {32{4'hD}};
    write_burst(BASE + 32'h80, 8'd1, INCR, 16'hffff, 0, resp);
    check("wlast_bresp", 128'(resp), 128'(2));
    edat[0] = {32{4'hC}};
    edat[1] = {32{4'hD}};
    read_burst(BASE + 32'h80, 8'd1, INCR, 2'b00, 1'b0, "wlast_rd");

    // 5) Stalled eight-beat read alongside an independent write burst.
    edat[0] = merged;
    edat[1] = {32{4'hB}};
    for (int k = 2; k < 8; k++) edat[k] = 128'(k);
    wbuf[0] = {32{4'hE}};
    wbuf[1] = {32{4'h7}};
    fork
      read_burst(BASE, 8'd7, INCR, 2'b00, 1'b1, "t5_rd");
      begin
        logic [1:0] r5;
        write_burst(BASE + 32'h140, 8'd1, INCR, 16'hffff, 1, r5);
        check("t5_bresp", 128'(r5), 128'(0));
      end
    join
    edat[0] = {32{4'hE}};
    edat[1] = {32{4'h7}};
    read_burst(BASE + 32'h140, 8'd1, INCR, 2'b00, 1'b0, "t5_back");

    // 6) Reset while the third beat of an eight-beat read is presented.
    ar_phase(BASE + 32'h20, 8'd7, INCR, ok);
    rready = 1'b1;
    cnt = 0; n = 0;
    while (cnt < 2 && n < 100) begin
      if (rvalid) cnt++;
      @(posedge clk); #1; n++;
    end
    n = 0;
    while (!rvalid && n < 50) begin @(posedge clk); #1; n++; end
    check("t6_beat3_vld",  128'(rvalid), 128'(1));
    check("t6_beat3_data", rdata, 128'(4));
    rready = 1'b0;
    rst_n = 1'b0;
    #2;
    check("t6_rst_rvalid",  128'(rvalid),  128'(0));
    check("t6_rst_arready", 128'(arready), 128'(1));
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("t6_post_rvalid", 128'(rvalid), 128'(0));
    check("t6_post_rlast",  128'(rlast),  128'(0));
    check("t6_post_arready", 128'(arready), 128'(1));
    for (int k = 0; k < 4; k++) edat[k] = 128'(k + 2);
    read_burst(BASE + 32'h20, 8'd3, INCR, 2'b00, 1'b0, "t6_rd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
